// File: rtl/picorv32_axi_bridge.sv
// picorv32 native memory port to AXI4-Lite master bridge, single outstanding request.
// Define PICORV32_AXI_TRACE_EN to add the trace_valid/trace_data completion port.
//
// flag    | meaning
// ack_ar  | AR handshake done for the current read request
// ack_aw  | AW handshake done for the current write request
// ack_w   | W handshake done for the current write request
// active  | out of reset; gates all bus-facing valids/readies
module picorv32_axi_bridge (
   input  logic        clk,
   input  logic        reset,

   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,

   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_awaddr,
   output logic [2:0]  mem_axi_awprot,

   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,

   input  logic        mem_axi_bvalid,
   output logic        mem_axi_bready,

   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic [31:0] mem_axi_araddr,
   output logic [2:0]  mem_axi_arprot,

   input  logic        mem_axi_rvalid,
   output logic        mem_axi_rready,
   input  logic [31:0] mem_axi_rdata,

   output logic        axi_err
`ifdef PICORV32_AXI_TRACE_EN
   ,
   output logic        trace_valid,
   output logic [35:0] trace_data
`endif
);

   logic        active;
   logic        ack_aw;
   logic        ack_w;
   logic        ack_ar;
   logic        pend_aw;
   logic        pend_w;
   logic        pend_ar;
   logic [31:0] hold_awaddr;
   logic [31:0] hold_wdata;
   logic [3:0]  hold_wstrb;
   logic [31:0] hold_araddr;
   logic        req_read;
   logic        req_write;
   logic        resp_err;
   logic        hold_err;

   assign req_read  = active && mem_valid && (mem_wstrb == 4'b0000);
   assign req_write = active && mem_valid && (mem_wstrb != 4'b0000);

   assign mem_axi_arvalid = req_read && !ack_ar;
   assign mem_axi_araddr  = mem_addr;
   assign mem_axi_arprot  = mem_instr ? 3'b100 : 3'b000;
   assign mem_axi_rready  = req_read;

   assign mem_axi_awvalid = req_write && !ack_aw;
   assign mem_axi_awaddr  = mem_addr;
   assign mem_axi_awprot  = 3'b000;
   assign mem_axi_wvalid  = req_write && !ack_w;
   assign mem_axi_wdata   = mem_wdata;
   assign mem_axi_wstrb   = mem_wstrb;
   assign mem_axi_bready  = req_write;

   assign mem_ready = (mem_axi_bvalid && mem_axi_bready) || (mem_axi_rvalid && mem_axi_rready);
   assign mem_rdata = mem_axi_rdata;

   // Responses are only legal while the matching request is being served.
   assign resp_err = active && ((mem_axi_rvalid && !req_read) || (mem_axi_bvalid && !req_write));

   // A valid left waiting last cycle must still be up, with unchanged payload.
   assign hold_err = (pend_ar && (!mem_axi_arvalid || (mem_axi_araddr != hold_araddr)))
                  || (pend_aw && (!mem_axi_awvalid || (mem_axi_awaddr != hold_awaddr)))
                  || (pend_w  && (!mem_axi_wvalid  || (mem_axi_wdata  != hold_wdata)
                                                   || (mem_axi_wstrb  != hold_wstrb)));

   always_ff @(posedge clk) begin
      if (reset) begin
         active      <= 1'b0;
         ack_aw      <= 1'b0;
         ack_w       <= 1'b0;
         ack_ar      <= 1'b0;
         pend_aw     <= 1'b0;
         pend_w      <= 1'b0;
         pend_ar     <= 1'b0;
         hold_awaddr <= 32'd0;
         hold_wdata  <= 32'd0;
         hold_wstrb  <= 4'd0;
         hold_araddr <= 32'd0;
         axi_err     <= 1'b0;
      end else begin
         active <= 1'b1;
         if (mem_ready || !mem_valid) begin
            ack_aw <= 1'b0;
            ack_w  <= 1'b0;
            ack_ar <= 1'b0;
         end else begin
            if (mem_axi_awvalid && mem_axi_awready) ack_aw <= 1'b1;
            if (mem_axi_wvalid  && mem_axi_wready)  ack_w  <= 1'b1;
            if (mem_axi_arvalid && mem_axi_arready) ack_ar <= 1'b1;
         end

         pend_aw     <= mem_axi_awvalid && !mem_axi_awready;
         pend_w      <= mem_axi_wvalid  && !mem_axi_wready;
         pend_ar     <= mem_axi_arvalid && !mem_axi_arready;
         hold_awaddr <= mem_axi_awaddr;
         hold_wdata  <= mem_axi_wdata;
         hold_wstrb  <= mem_axi_wstrb;
         hold_araddr <= mem_axi_araddr;

         if (resp_err || hold_err) axi_err <= 1'b1;
      end
   end

`ifdef PICORV32_AXI_TRACE_EN
   assign trace_valid = mem_ready;
   assign trace_data  = mem_ready ? {req_write, mem_instr, 2'b00,
                                     req_write ? mem_wdata : mem_axi_rdata}
                                  : 36'd0;
`endif

endmodule

// File: tb/tb_picorv32_axi_bridge.sv
// Self-checking bench for picorv32_axi_bridge: directed scenarios plus a randomized
// slave with a transaction-level model (shadow memory, per-request handshake state).
module tb_picorv32_axi_bridge;

   localparam int N_TXN     = 1000;
   localparam int CYC_LIMIT = 60000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [3:0]  mem_wstrb = 4'd0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_axi_awvalid;
   logic        mem_axi_awready = 1'b0;
   logic [31:0] mem_axi_awaddr;
   logic [2:0]  mem_axi_awprot;
   logic        mem_axi_wvalid;
   logic        mem_axi_wready = 1'b0;
   logic [31:0] mem_axi_wdata;
   logic [3:0]  mem_axi_wstrb;
   logic        mem_axi_bvalid = 1'b0;
   logic        mem_axi_bready;
   logic        mem_axi_arvalid;
   logic        mem_axi_arready = 1'b0;
   logic [31:0] mem_axi_araddr;
   logic [2:0]  mem_axi_arprot;
   logic        mem_axi_rvalid = 1'b0;
   logic        mem_axi_rready;
   logic [31:0] mem_axi_rdata = 32'd0;
   logic        axi_err;
`ifdef PICORV32_AXI_TRACE_EN
   logic        trace_valid;
   logic [35:0] trace_data;
`endif

   picorv32_axi_bridge dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
      .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
      .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
      .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
      .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
      .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
      .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
      .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
      .mem_axi_rdata(mem_axi_rdata),
      .axi_err(axi_err)
`ifdef PICORV32_AXI_TRACE_EN
      , .trace_valid(trace_valid), .trace_data(trace_data)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   logic [63:0] xs;
   function automatic logic [31:0] rnd();
      xs = xs ^ (xs << 13);
      xs = xs ^ (xs >> 7);
      xs = xs ^ (xs << 17);
      return xs[31:0];
   endfunction

   function automatic logic [31:0] wmerge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // model / random-slave state
   logic [31:0] shadow [16];
   logic [31:0] smem [16];
   logic        ar_done, aw_done, w_done;
   int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
   logic        r_pend, b_pend, got_aw, got_w;
   logic [31:0] r_data, cap_awaddr, cap_wdata;
   logic [3:0]  cap_wstrb;
   int          n_start, n_done, n_ready_seen, cyc, idle;

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        is_rd, is_wr, e_ar, e_aw, e_w, e_ready;
      logic        hs_ar, hs_aw, hs_w, hs_r, hs_b;
      logic [31:0] s_araddr, s_awaddr, s_wdata, r;
      logic [3:0]  s_wstrb, idx;
      int          kind;

      // reset holds every bus output low even with a request presented
      mem_valid = 1'b1;
      tick(); tick(); tick();
      mid();
      chk("rst_arvalid", mem_axi_arvalid, 0);
      chk("rst_rready", mem_axi_rready, 0);
      chk("rst_awvalid", mem_axi_awvalid, 0);
      chk("rst_wvalid", mem_axi_wvalid, 0);
      chk("rst_bready", mem_axi_bready, 0);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_axi_err", axi_err, 0);
      tick();
      mem_valid = 1'b0;
      reset = 1'b0;
      tick();

      // instruction fetch against a zero-wait slave
      mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'b0;
      mem_axi_arready = 1'b1;
      mid();
      chk("fetch_arvalid", mem_axi_arvalid, 1);
      chk("fetch_arprot", mem_axi_arprot, 3'b100);
      chk("fetch_rready", mem_axi_rready, 1);
      chk("fetch_ready0", mem_ready, 0);
      tick();
      mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'h0000_0093;
      mid();
      chk("fetch_ar_dropped", mem_axi_arvalid, 0);
      chk("fetch_ready", mem_ready, 1);
      chk("fetch_rdata", mem_rdata, 32'h0000_0093);
`ifdef PICORV32_AXI_TRACE_EN
      chk("fetch_trace_valid", trace_valid, 1);
      chk("fetch_trace_data", trace_data, 36'h4_0000_0093);
`endif
      tick();
      mem_axi_rvalid = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
      mid();
      chk("fetch_ready_end", mem_ready, 0);

      // write with W accepted three cycles after AW
      tick();
      mem_valid = 1'b1; mem_addr = 32'h1000_0000; mem_wdata = 32'h41; mem_wstrb = 4'b0001;
      mem_axi_awready = 1'b1;
      mid();
      chk("w1_awvalid", mem_axi_awvalid, 1);
      chk("w1_wvalid", mem_axi_wvalid, 1);
      chk("w1_awaddr", mem_axi_awaddr, 32'h1000_0000);
      chk("w1_wstrb", mem_axi_wstrb, 4'b0001);
      chk("w1_bready", mem_axi_bready, 1);
      chk("w1_arvalid", mem_axi_arvalid, 0);
      tick();
      mem_axi_awready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mid();
         chk("w1_aw_dropped", mem_axi_awvalid, 0);
         chk("w1_w_held", mem_axi_wvalid, 1);
         chk("w1_ready_wait", mem_ready, 0);
         tick();
      end
      mem_axi_wready = 1'b1;
      mid();
      chk("w1_w_held_last", mem_axi_wvalid, 1);
      chk("w1_wdata", mem_axi_wdata, 32'h41);
      tick();
      mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b1;
      mid();
      chk("w1_w_dropped", mem_axi_wvalid, 0);
      chk("w1_ready", mem_ready, 1);
      tick();
      mem_axi_bvalid = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'b0;
      mid();
      chk("w1_ready_once", mem_ready, 0);
      chk("w1_err", axi_err, 0);

      // write with AW and W in the same cycle
      tick();
      mem_valid = 1'b1; mem_addr = 32'h2000_0000; mem_wdata = 32'd123456789; mem_wstrb = 4'hF;
      mem_axi_awready = 1'b1; mem_axi_wready = 1'b1;
      mid();
      chk("w2_awvalid", mem_axi_awvalid, 1);
      chk("w2_wvalid", mem_axi_wvalid, 1);
      chk("w2_wdata", mem_axi_wdata, 32'd123456789);
      chk("w2_awprot", mem_axi_awprot, 0);
      tick();
      mem_axi_awready = 1'b0; mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b1;
      mid();
      chk("w2_aw_dropped", mem_axi_awvalid, 0);
      chk("w2_w_dropped", mem_axi_wvalid, 0);
      chk("w2_ready", mem_ready, 1);
`ifdef PICORV32_AXI_TRACE_EN
      chk("w2_trace_data", trace_data, 36'h8_075B_CD15);
`endif
      tick();
      mem_axi_bvalid = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'b0;
      mid();
      chk("w2_ready_once", mem_ready, 0);

      // spurious read response is sticky until reset
      tick();
      mem_axi_rvalid = 1'b1;
      mid();
      chk("spur_ready", mem_ready, 0);
      chk("spur_err_pre", axi_err, 0);
      tick();
      mem_axi_rvalid = 1'b0;
      mid();
      chk("spur_err_set", axi_err, 1);
      tick(); tick();
      mid();
      chk("spur_err_sticky", axi_err, 1);
      reset_pulse();
      mid();
      chk("spur_err_cleared", axi_err, 0);

      // core changing the address before AR handshake
      tick();
      mem_valid = 1'b1; mem_addr = 32'h40; mem_wstrb = 4'b0;
      tick();
      mem_addr = 32'h44;
      mid();
      chk("hold_err_pre", axi_err, 0);
      tick();
      mid();
      chk("hold_err_set", axi_err, 1);
      tick();
      mem_valid = 1'b0;
      reset_pulse();

      // reset while a read address is waiting; late response ignored
      mem_valid = 1'b1; mem_addr = 32'h300;
      mid();
      chk("rmid_arvalid", mem_axi_arvalid, 1);
      tick();
      reset = 1'b1;
      tick();
      mem_axi_rvalid = 1'b1;
      mid();
      chk("rmid_ar_dropped", mem_axi_arvalid, 0);
      chk("rmid_ready", mem_ready, 0);
`ifdef PICORV32_AXI_TRACE_EN
      chk("rmid_trace_valid", trace_valid, 0);
`endif
      tick();
      reset = 1'b0; mem_axi_rvalid = 1'b0; mem_valid = 1'b0;
      tick();
      mid();
      chk("rmid_err", axi_err, 0);
      tick();

      // randomized traffic against transaction-level model
      xs = 64'd88172645463325252;
      for (int i = 0; i < 16; i++) begin
         shadow[i] = 32'hC0DE_0000 | i;
         smem[i]   = 32'hC0DE_0000 | i;
      end
      ar_done = 0; aw_done = 0; w_done = 0;
      ar_cnt = -1; aw_cnt = -1; w_cnt = -1; r_cnt = 0; b_cnt = 0;
      r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
      r_data = 0; cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0;
      n_start = 0; n_done = 0; n_ready_seen = 0; cyc = 0; idle = 0;

      while (n_done < N_TXN && cyc < CYC_LIMIT) begin
         mid();
         cyc++;
         is_rd   = mem_valid && (mem_wstrb == 4'b0);
         is_wr   = mem_valid && (mem_wstrb != 4'b0);
         e_ar    = is_rd && !ar_done;
         e_aw    = is_wr && !aw_done;
         e_w     = is_wr && !w_done;
         e_ready = (mem_axi_rvalid && is_rd) || (mem_axi_bvalid && is_wr);
         chk("arvalid", mem_axi_arvalid, e_ar);
         chk("awvalid", mem_axi_awvalid, e_aw);
         chk("wvalid", mem_axi_wvalid, e_w);
         chk("rready", mem_axi_rready, is_rd);
         chk("bready", mem_axi_bready, is_wr);
         chk("mem_ready", mem_ready, e_ready);
         chk("axi_err", axi_err, 0);
         if (e_ar) begin
            chk("araddr", mem_axi_araddr, mem_addr);
            chk("arprot", mem_axi_arprot, mem_instr ? 64'd4 : 64'd0);
         end
         if (e_aw) begin
            chk("awaddr", mem_axi_awaddr, mem_addr);
            chk("awprot", mem_axi_awprot, 0);
         end
         if (e_w) begin
            chk("wdata", mem_axi_wdata, mem_wdata);
            chk("wstrb", mem_axi_wstrb, mem_wstrb);
         end
         if (e_ready && is_rd) chk("rdata", mem_rdata, shadow[mem_addr[5:2]]);
`ifdef PICORV32_AXI_TRACE_EN
         chk("trace_valid", trace_valid, e_ready);
         chk("trace_data", trace_data,
             e_ready ? {28'd0, is_wr, mem_instr, 2'b00, is_wr ? mem_wdata : mem_axi_rdata} : 64'd0);
`endif
         if (mem_ready) n_ready_seen++;
         hs_ar = e_ar && mem_axi_arready;
         hs_aw = e_aw && mem_axi_awready;
         hs_w  = e_w  && mem_axi_wready;
         hs_r  = mem_axi_rvalid && is_rd;
         hs_b  = mem_axi_bvalid && is_wr;
         s_araddr = mem_axi_araddr;
         s_awaddr = mem_axi_awaddr;
         s_wdata  = mem_axi_wdata;
         s_wstrb  = mem_axi_wstrb;
         tick();

         if (e_ready) begin
            if (is_wr) shadow[mem_addr[5:2]] = wmerge(shadow[mem_addr[5:2]], mem_wdata, mem_wstrb);
            n_done++;
            mem_valid = 1'b0;
            ar_done = 0; aw_done = 0; w_done = 0;
            idle = int'(rnd() % 3);
         end else begin
            if (hs_ar) ar_done = 1;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
         end

         if (hs_ar) begin
            mem_axi_arready = 1'b0;
            r_pend = 1; r_cnt = int'(rnd() % 5); r_data = smem[s_araddr[5:2]];
         end else if (e_ar && !mem_axi_arready) begin
            if (ar_cnt < 0) ar_cnt = int'(rnd() % 5);
            if (ar_cnt == 0) begin mem_axi_arready = 1'b1; ar_cnt = -1; end
            else ar_cnt--;
         end
         if (hs_r) begin mem_axi_rvalid = 1'b0; mem_axi_rdata = $urandom; end
         if (r_pend) begin
            if (r_cnt == 0) begin mem_axi_rvalid = 1'b1; mem_axi_rdata = r_data; r_pend = 0; end
            else r_cnt--;
         end

         if (hs_aw) begin
            mem_axi_awready = 1'b0; got_aw = 1; cap_awaddr = s_awaddr;
         end else if (e_aw && !mem_axi_awready) begin
            if (aw_cnt < 0) aw_cnt = int'(rnd() % 5);
            if (aw_cnt == 0) begin mem_axi_awready = 1'b1; aw_cnt = -1; end
            else aw_cnt--;
         end
         if (hs_w) begin
            mem_axi_wready = 1'b0; got_w = 1; cap_wdata = s_wdata; cap_wstrb = s_wstrb;
         end else if (e_w && !mem_axi_wready) begin
            if (w_cnt < 0) w_cnt = int'(rnd() % 5);
            if (w_cnt == 0) begin mem_axi_wready = 1'b1; w_cnt = -1; end
            else w_cnt--;
         end
         if (got_aw && got_w) begin
            smem[cap_awaddr[5:2]] = wmerge(smem[cap_awaddr[5:2]], cap_wdata, cap_wstrb);
            got_aw = 0; got_w = 0; b_pend = 1; b_cnt = int'(rnd() % 5);
         end
         if (hs_b) mem_axi_bvalid = 1'b0;
         if (b_pend) begin
            if (b_cnt == 0) begin mem_axi_bvalid = 1'b1; b_pend = 0; end
            else b_cnt--;
         end

         if (!mem_valid && n_start < N_TXN) begin
            if (idle > 0) idle--;
            else begin
               kind = int'(rnd() % 3);
               r = rnd();
               idx = r[3:0];
               mem_addr  = 32'h1000_0000 | {26'd0, idx, 2'b00};
               mem_instr = (kind == 1);
               mem_wdata = rnd();
               mem_wstrb = (kind == 2) ? 4'(rnd() % 15 + 1) : 4'b0;
               mem_valid = 1'b1;
               n_start++;
            end
         end
      end

      chk("rand_txn_done", n_done, N_TXN);
      chk("rand_ready_pulses", n_ready_seen, N_TXN);
      for (int i = 0; i < 16; i++) chk("rand_mem_word", smem[i], shadow[i]);
      mid();
      chk("rand_err_final", axi_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
